hazard_stall_ctrl: RTL and testbench

- Producer-side hazard controller for the 5-stage MIPS pipeline. It complements the EX-stage forwarding unit by handling the cases forwarding cannot resolve:
  - load-use hazards, by stalling IF/ID and inserting an ID/EX bubble;
  - taken-branch squash, by flushing IF/ID and ID/EX;
  - multi-cycle mult/div occupancy of EX, by freezing the front end and bubbling EX/MEM.
- It also holds saturating stall and flush performance counters.

---
 rtl/pipeline_pkg.sv | 18 +
 rtl/sat_counter.sv | 26 ++
 rtl/hazard_stall_ctrl.sv | 136 +++++++++++++
 tb/tb_hazard_stall_ctrl.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/pipeline_pkg.sv
// +--------------------------------------------------------------------------+
// | pipeline_pkg: state encoding and register constants shared by the         |
// | hazard controller and the forwarding unit. Revision 1.0                   |
// +--------------------------------------------------------------------------+
`default_nettype none

package pipeline_pkg;

    typedef enum logic {
        RUN    = 1'b0,
        MDBUSY = 1'b1
    } state_t;

    localparam logic [4:0] REG_ZERO = 5'd0;

endpackage

`default_nettype wire

// File: rtl/sat_counter.sv
// +--------------------------------------------------------------------------+
// | sat_counter: event counter that sticks at its all-ones maximum.           |
// | Revision 1.0                                                              |
// +--------------------------------------------------------------------------+
`default_nettype none

module sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         inc,
    output logic [W-1:0] count
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (inc && (count != {W{1'b1}})) begin
            count <= count + 1'b1;
        end
    end

endmodule

`default_nettype wire

// File: rtl/hazard_stall_ctrl.sv
// +--------------------------------------------------------------------------+
// | hazard_stall_ctrl: load-use stall, taken-branch squash and mult/div EX    |
// | occupancy control for the 5-stage pipeline, with perf counters.           |
// | Revision 1.0                                                              |
// +--------------------------------------------------------------------------+
`default_nettype none

module hazard_stall_ctrl
    import pipeline_pkg::*;
#(
    parameter int MULDIV_LATENCY = 4,
    parameter int CNT_W          = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [4:0]       ID_RegisterRs,
    input  logic [4:0]       ID_RegisterRt,
    input  logic             ID_UsesRs,
    input  logic             ID_UsesRt,
    input  logic             EX_MemRead,
    input  logic [4:0]       EX_Write_register,
    input  logic             EX_BranchTaken,
    input  logic             EX_MulDivStart,
    output logic             PC_Write,
    output logic             IF_ID_Write,
    output logic             IF_ID_Flush,
    output logic             ID_EX_Write,
    output logic             ID_EX_Flush,
    output logic             EX_MEM_Bubble,
    output logic             MulDivDone,
    output logic [CNT_W-1:0] Stall_Count,
    output logic [CNT_W-1:0] Flush_Count
);

    localparam int             REM_W        = 5;
    localparam logic [REM_W-1:0] REM_INIT   = REM_W'(MULDIV_LATENCY - 1);
    localparam bit             SINGLE_CYCLE = (MULDIV_LATENCY == 1);

    state_t           state;
    state_t           state_nxt;
    logic [REM_W-1:0] rem;
    logic [REM_W-1:0] rem_nxt;
    logic             load_use;
    logic             flush_event;

    assign load_use = EX_MemRead && (EX_Write_register != REG_ZERO) &&
                      ((ID_UsesRs && (EX_Write_register == ID_RegisterRs)) ||
                       (ID_UsesRt && (EX_Write_register == ID_RegisterRt)));

    // Outputs are gated by rst_n so the pipeline runs freely while in reset,
    // whatever the inputs happen to be.
    always_comb begin
        PC_Write      = 1'b1;
        IF_ID_Write   = 1'b1;
        IF_ID_Flush   = 1'b0;
        ID_EX_Write   = 1'b1;
        ID_EX_Flush   = 1'b0;
        EX_MEM_Bubble = 1'b0;
        MulDivDone    = 1'b0;
        flush_event   = 1'b0;
        state_nxt     = state;
        rem_nxt       = rem;
        if (rst_n) begin
            case (state)
                RUN: begin
                    if (EX_BranchTaken) begin
                        IF_ID_Flush = 1'b1;
                        ID_EX_Flush = 1'b1;
                        flush_event = 1'b1;
                    end else if (EX_MulDivStart) begin
                        if (SINGLE_CYCLE) begin
                            MulDivDone = 1'b1;
                        end else begin
                            PC_Write      = 1'b0;
                            IF_ID_Write   = 1'b0;
                            ID_EX_Write   = 1'b0;
                            EX_MEM_Bubble = 1'b1;
                            rem_nxt       = REM_INIT;
                            state_nxt     = MDBUSY;
                        end
                    end else if (load_use) begin
                        PC_Write    = 1'b0;
                        IF_ID_Write = 1'b0;
                        ID_EX_Flush = 1'b1;
                    end
                end
                MDBUSY: begin
                    // The held EX instruction keeps EX_MulDivStart high; it
                    // must not restart the sequence, so all events are ignored.
                    if (rem > REM_W'(1)) begin
                        PC_Write      = 1'b0;
                        IF_ID_Write   = 1'b0;
                        ID_EX_Write   = 1'b0;
                        EX_MEM_Bubble = 1'b1;
                        rem_nxt       = rem - 1'b1;
                    end else begin
                        MulDivDone = 1'b1;
                        rem_nxt    = '0;
                        state_nxt  = RUN;
                    end
                end
                default: begin
                    state_nxt = RUN;
                    rem_nxt   = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= RUN;
            rem   <= '0;
        end else begin
            state <= state_nxt;
            rem   <= rem_nxt;
        end
    end

    sat_counter #(.W(CNT_W)) u_stall_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (!PC_Write),
        .count (Stall_Count)
    );

    sat_counter #(.W(CNT_W)) u_flush_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (flush_event),
        .count (Flush_Count)
    );

endmodule

`default_nettype wire

// File: tb/tb_hazard_stall_ctrl.sv
// +--------------------------------------------------------------------------+
// | tb_hazard_stall_ctrl: directed self-checking bench for hazard_stall_ctrl. |
// | Revision 1.0                                                              |
// +--------------------------------------------------------------------------+
`default_nettype none

module tb_hazard_stall_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [4:0]  ID_RegisterRs, ID_RegisterRt, EX_Write_register;
    logic        ID_UsesRs, ID_UsesRt, EX_MemRead, EX_BranchTaken, EX_MulDivStart;

    logic        PC_Write, IF_ID_Write, IF_ID_Flush, ID_EX_Write, ID_EX_Flush;
    logic        EX_MEM_Bubble, MulDivDone;
    logic [15:0] Stall_Count, Flush_Count;

    logic        s_PC_Write, s_IF_ID_Write, s_IF_ID_Flush, s_ID_EX_Write, s_ID_EX_Flush;
    logic        s_EX_MEM_Bubble, s_MulDivDone;
    logic [1:0]  s_Stall_Count, s_Flush_Count;

    int checks = 0;
    int errors = 0;

    // {PC_Write, IF_ID_Write, IF_ID_Flush, ID_EX_Write, ID_EX_Flush, EX_MEM_Bubble, MulDivDone}
    localparam logic [6:0] DEF    = 7'b1101000;
    localparam logic [6:0] LDUSE  = 7'b0001100;
    localparam logic [6:0] BRANCH = 7'b1111100;
    localparam logic [6:0] FREEZE = 7'b0000010;
    localparam logic [6:0] DONE   = 7'b1101001;

    always #5 clk = ~clk;

    hazard_stall_ctrl #(.MULDIV_LATENCY(4), .CNT_W(16)) dut (
        .clk(clk), .rst_n(rst_n),
        .ID_RegisterRs(ID_RegisterRs), .ID_RegisterRt(ID_RegisterRt),
        .ID_UsesRs(ID_UsesRs), .ID_UsesRt(ID_UsesRt),
        .EX_MemRead(EX_MemRead), .EX_Write_register(EX_Write_register),
        .EX_BranchTaken(EX_BranchTaken), .EX_MulDivStart(EX_MulDivStart),
        .PC_Write(PC_Write), .IF_ID_Write(IF_ID_Write), .IF_ID_Flush(IF_ID_Flush),
        .ID_EX_Write(ID_EX_Write), .ID_EX_Flush(ID_EX_Flush),
        .EX_MEM_Bubble(EX_MEM_Bubble), .MulDivDone(MulDivDone),
        .Stall_Count(Stall_Count), .Flush_Count(Flush_Count)
    );

    hazard_stall_ctrl #(.MULDIV_LATENCY(4), .CNT_W(2)) dut_sat (
        .clk(clk), .rst_n(rst_n),
        .ID_RegisterRs(ID_RegisterRs), .ID_RegisterRt(ID_RegisterRt),
        .ID_UsesRs(ID_UsesRs), .ID_UsesRt(ID_UsesRt),
        .EX_MemRead(EX_MemRead), .EX_Write_register(EX_Write_register),
        .EX_BranchTaken(EX_BranchTaken), .EX_MulDivStart(EX_MulDivStart),
        .PC_Write(s_PC_Write), .IF_ID_Write(s_IF_ID_Write), .IF_ID_Flush(s_IF_ID_Flush),
        .ID_EX_Write(s_ID_EX_Write), .ID_EX_Flush(s_ID_EX_Flush),
        .EX_MEM_Bubble(s_EX_MEM_Bubble), .MulDivDone(s_MulDivDone),
        .Stall_Count(s_Stall_Count), .Flush_Count(s_Flush_Count)
    );

    // Branch and mult/div together is an illegal stimulus.
    always @(negedge clk) begin
        if (rst_n) assert (!(EX_BranchTaken && EX_MulDivStart))
            else $error("illegal stimulus: branch and mult/div together");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_ctl(input string tag, input logic [6:0] exp);
        chk(tag, {25'd0, PC_Write, IF_ID_Write, IF_ID_Flush, ID_EX_Write,
                  ID_EX_Flush, EX_MEM_Bubble, MulDivDone}, {25'd0, exp});
    endtask

    task automatic clear_in();
        ID_RegisterRs = 5'd0; ID_RegisterRt = 5'd0;
        ID_UsesRs = 1'b0; ID_UsesRt = 1'b0;
        EX_MemRead = 1'b0; EX_Write_register = 5'd0;
        EX_BranchTaken = 1'b0; EX_MulDivStart = 1'b0;
    endtask

    task automatic set_load_use_rs();
        EX_MemRead = 1'b1; EX_Write_register = 5'd8;
        ID_RegisterRs = 5'd8; ID_UsesRs = 1'b1;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        // Reset with a load-use pattern on the inputs: outputs stay at defaults.
        rst_n = 1'b0;
        clear_in();
        set_load_use_rs();
        #1;
        chk_ctl("reset_forced_defaults", DEF);
        chk("reset_stall_cnt", 32'(Stall_Count), 32'd0);
        chk("reset_flush_cnt", 32'(Flush_Count), 32'd0);
        tick();
        tick();
        rst_n = 1'b1;
        clear_in();
        #1;
        chk_ctl("idle_defaults", DEF);

        // Load-use on rs: one stall cycle, then the bubble in EX clears it.
        set_load_use_rs();
        #1;
        chk_ctl("load_use_rs", LDUSE);
        tick();
        clear_in();
        #1;
        chk_ctl("after_bubble", DEF);
        chk("stall_cnt_1", 32'(Stall_Count), 32'd1);

        // No false stall: load to $zero.
        EX_MemRead = 1'b1; EX_Write_register = 5'd0;
        ID_RegisterRs = 5'd0; ID_UsesRs = 1'b1;
        #1;
        chk_ctl("no_stall_reg_zero", DEF);
        tick();
        chk("stall_cnt_zero_reg", 32'(Stall_Count), 32'd1);

        // No false stall: rt matches but is not read.
        clear_in();
        EX_MemRead = 1'b1; EX_Write_register = 5'd9;
        ID_RegisterRt = 5'd9; ID_UsesRt = 1'b0;
        #1;
        chk_ctl("no_stall_rt_unused", DEF);
        tick();
        chk("stall_cnt_rt_unused", 32'(Stall_Count), 32'd1);

        // Same rt match, now read: real hazard.
        ID_UsesRt = 1'b1;
        #1;
        chk_ctl("load_use_rt", LDUSE);
        tick();
        clear_in();
        #1;
        chk("stall_cnt_2", 32'(Stall_Count), 32'd2);

        // Branch beats load-use.
        set_load_use_rs();
        EX_BranchTaken = 1'b1;
        #1;
        chk_ctl("branch_over_load_use", BRANCH);
        tick();
        clear_in();
        #1;
        chk("flush_cnt_1", 32'(Flush_Count), 32'd1);
        chk("stall_cnt_after_branch", 32'(Stall_Count), 32'd2);

        // Mult/div, latency 4, start held for 4 cycles.
        EX_MulDivStart = 1'b1;
        #1;
        chk_ctl("muldiv_c1", FREEZE);
        tick();
        chk_ctl("muldiv_c2", FREEZE);
        tick();
        set_load_use_rs();
        #1;
        chk_ctl("muldiv_c3_ignores_load_use", FREEZE);
        tick();
        chk_ctl("muldiv_c4_done", DONE);
        tick();
        clear_in();
        #1;
        chk_ctl("muldiv_no_retrigger", DEF);
        chk("stall_cnt_muldiv", 32'(Stall_Count), 32'd5);

        // Reset during the second MDBUSY cycle abandons the operation.
        EX_MulDivStart = 1'b1;
        tick();
        tick();
        rst_n = 1'b0;
        #1;
        chk_ctl("reset_mid_muldiv", DEF);
        chk("reset_mid_stall_cnt", 32'(Stall_Count), 32'd0);
        chk("reset_mid_flush_cnt", 32'(Flush_Count), 32'd0);
        tick();
        rst_n = 1'b1;
        clear_in();
        for (int i = 0; i < 4; i++) begin
            #1;
            chk("no_done_after_reset", {31'd0, MulDivDone}, 32'd0);
            tick();
        end
        set_load_use_rs();
        #1;
        chk_ctl("back_in_run", LDUSE);
        tick();
        clear_in();

        // Saturation: 5 branches into a 2-bit counter.
        for (int i = 0; i < 5; i++) begin
            EX_BranchTaken = 1'b1;
            #1;
            chk_ctl("sat_branch", BRANCH);
            tick();
        end
        clear_in();
        #1;
        chk("flush_cnt_wide_5", 32'(Flush_Count), 32'd5);
        chk("flush_cnt_sat_3", 32'(s_Flush_Count), 32'd3);
        chk("stall_cnt_after_reset", 32'(Stall_Count), 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "timeout");
    end

endmodule

`default_nettype wire
